dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports CLK and SCLR.
REQ-002 Parameters SHALL be as follows:
- DATA_W, default 64: operand and result width.
- DSP_LAT, default 3: cycles from DSP input edge to P valid.
- FIFO_DEPTH, default 8: result buffer entries; must be at least DSP_LAT+2.
REQ-003 Ports SHALL be as follows:
- CLK  in  1  clock.
- SCLR  in  1  synchronous reset.
- prec_mode  in  LOG_ALLOWED_PRECISIONS  lane enables (bit0 = 8b lane0, bit1 = 8b lane1, bit2 = 16b, bit3 = 32b).
- chain_mode  in  1  request full 64b chained MAC.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat accepted.
- s_a, s_b, s_c  in  DATA_W each  operands.
- s_last  in  1  last beat of packet.
- dsp_ce  out  LOG_ALLOWED_PRECISIONS  DSP lane enables.
- dsp_active_chain  out  1  DSP chain select.
- dsp_a, dsp_b, dsp_c  out  DATA_W  DSP operands.
- dsp_p  in  DATA_W  DSP result.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed.
- m_data  out  DATA_W  result.
- m_last  out  1  last result of packet.
- cfg_err  out  1  sticky illegal chain request.
- busy  out  1  packet in progress or results pending.

Function
REQ-004 A beat SHALL be accepted on an edge where s_valid and s_ready are both high.
REQ-005 All dsp_* outputs SHALL be registered; an accepted beat SHALL appear on dsp_a/dsp_b/dsp_c in the cycle after acceptance.
REQ-006 In cycles with no beat issued, dsp_a/dsp_b/dsp_c SHALL be driven to zero, and the resulting DSP output SHALL NOT be captured.
REQ-007 An FSM SHALL have the states IDLE, RUN and DRAIN:
- IDLE to RUN on acceptance of a first beat with s_last=0.
- IDLE to DRAIN on acceptance of a first beat with s_last=1.
- RUN to DRAIN on acceptance of a beat with s_last=1.
- DRAIN to IDLE once the in-flight count is zero.
REQ-008 prec_mode and chain_mode SHALL be latched on the first beat of a packet and held on dsp_ce/dsp_active_chain until DRAIN exits; changes mid-packet SHALL be ignored.
REQ-009 dsp_ce SHALL be zero and dsp_active_chain zero in IDLE.
REQ-010 If chain_mode=1 is latched with prec_mode not equal to 4'b1111, dsp_active_chain SHALL be forced to 0 and cfg_err SHALL set, remaining set until SCLR; the beats SHALL still be processed.
REQ-011 A DSP_LAT+1 deep valid/last shift register SHALL track in-flight beats; dsp_p SHALL be pushed into the FIFO, together with the last flag, on edge E0+DSP_LAT+1, where E0 is the acceptance edge.
REQ-012 Minimum acceptance-to-m_valid latency SHALL be DSP_LAT+1 cycles; results SHALL leave in acceptance order.
REQ-013 s_ready SHALL be high only in IDLE or RUN, and only when FIFO occupancy plus in-flight count is less than FIFO_DEPTH, computed from registered counts. A pop in the same cycle SHALL raise s_ready only in the next cycle.
REQ-014 The FIFO SHALL never overflow or underflow. Simultaneous push and pop SHALL leave occupancy unchanged, including when full.
REQ-015 m_valid SHALL be high whenever the FIFO is non-empty; m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-016 m_data SHALL equal dsp_p verbatim, with no lane reinterpretation.
REQ-017 busy SHALL be high when the state is not IDLE or the FIFO is non-empty.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-019 On SCLR the block SHALL return to IDLE and clear the FIFO, shift register, counts, latched configuration and cfg_err.
REQ-020 On SCLR all outputs SHALL go to 0 on the next edge, with s_ready rising one cycle after SCLR deasserts.
REQ-021 On SCLR mid-packet, in-flight results SHALL be discarded and never presented on m_*.

Structure
REQ-022 LOG_ALLOWED_PRECISIONS, the DSP_LAT default and the FSM state encoding SHALL reside in the shared precision definitions package/header.
REQ-023 The result buffer SHALL be a separate sub-module, dsp_res_fifo (a synchronous FIFO with occupancy count).

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Single beat: prec_mode=4'b1111, chain_mode=1, a=3, b=5, c=7, s_last=1 with m_ready=1 -> dsp_active_chain=1; m_data=22 and m_last=1 exactly 4 cycles after acceptance; back to IDLE with busy=0.
- Stream of 8 beats with m_ready=0 -> s_ready drops after 8 accepted beats (occupancy plus in-flight = 8); no beat lost; releasing m_ready drains 8 results in order.
- Mid-packet config change: prec_mode changes from 4'b0011 to 4'b1111 on beat 2 of 4 -> dsp_ce stays 4'b0011 until DRAIN exits.
- Illegal chain: chain_mode=1 with prec_mode=4'b0101 -> cfg_err=1, dsp_active_chain=0, results still delivered.
- SCLR asserted with 3 beats in flight -> m_valid stays 0 thereafter; state IDLE; cfg_err cleared.
- Push and pop in the same cycle with the FIFO full -> occupancy stays at 8 and data order is preserved.

Source files
------------

// File: rtl/dsp_mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mac_sequencer_pkg
//  Description : Shared precision definitions, DSP latency default and the
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_mac_sequencer_pkg;

    localparam int LOG_ALLOWED_PRECISIONS = 4;
    localparam int DSP_LAT_DEFAULT        = 3;

    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_ALL_LANES = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Full 64b chaining only makes sense when every lane participates.
    function automatic logic chain_legal(input logic [LOG_ALLOWED_PRECISIONS-1:0] prec);
        return prec == PREC_ALL_LANES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_res_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_res_fifo
//  Description : Synchronous result FIFO with occupancy count; a push while
//                full is taken only when a pop happens on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_res_fifo
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mac_sequencer
//  Description : Feeds operand beats to an external pipelined DSP MAC, tracks
//                in-flight results and buffers them in an output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DSP_LAT    = DSP_LAT_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              CLK,
    input  logic                              SCLR,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] prec_mode,
    input  logic                              chain_mode,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_a,
    input  logic [DATA_W-1:0]                 s_b,
    input  logic [DATA_W-1:0]                 s_c,
    input  logic                              s_last,
    output logic [LOG_ALLOWED_PRECISIONS-1:0] dsp_ce,
    output logic                              dsp_active_chain,
    output logic [DATA_W-1:0]                 dsp_a,
    output logic [DATA_W-1:0]                 dsp_b,
    output logic [DATA_W-1:0]                 dsp_c,
    input  logic [DATA_W-1:0]                 dsp_p,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_W-1:0]                 m_data,
    output logic                              m_last,
    output logic                              cfg_err,
    output logic                              busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] c_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);

    seq_state_t                        r_state;
    seq_state_t                        w_state_nxt;
    logic [LOG_ALLOWED_PRECISIONS-1:0] r_prec;
    logic                              r_chain;
    logic [LOG_ALLOWED_PRECISIONS-1:0] w_prec_nxt;
    logic                              w_chain_nxt;
    logic                              r_cfg_err;
    logic                              r_rdy_en;
    logic [DSP_LAT:0]                  r_vld;
    logic [DSP_LAT:0]                  r_last;
    logic [CNT_W-1:0]                  r_inflight;
    logic [LOG_ALLOWED_PRECISIONS-1:0] r_dsp_ce;
    logic                              r_dsp_chain;
    logic [DATA_W-1:0]                 r_dsp_a;
    logic [DATA_W-1:0]                 r_dsp_b;
    logic [DATA_W-1:0]                 r_dsp_c;

    logic                              w_accept;
    logic                              w_first;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_fifo_empty;
    logic [CNT_W-1:0]                  w_fifo_count;
    logic [DATA_W:0]                   w_fifo_dout;
    logic [CNT_W:0]                    w_pending;

    // Credit check uses registered counts only, so a pop frees a slot one cycle later.
    assign w_pending = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign s_ready   = r_rdy_en
                     && ((r_state == ST_IDLE) || (r_state == ST_RUN))
                     && (w_pending < c_DEPTH);

    assign w_accept    = s_valid && s_ready;
    assign w_first     = w_accept && (r_state == ST_IDLE);
    assign w_prec_nxt  = w_first ? prec_mode  : r_prec;
    assign w_chain_nxt = w_first ? chain_mode : r_chain;
    assign w_push      = r_vld[DSP_LAT];
    assign w_pop       = m_valid && m_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = s_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && s_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_inflight == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            r_state     <= ST_IDLE;
            r_prec      <= '0;
            r_chain     <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_rdy_en    <= 1'b0;
            r_vld       <= '0;
            r_last      <= '0;
            r_inflight  <= '0;
            r_dsp_ce    <= '0;
            r_dsp_chain <= 1'b0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_dsp_c     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rdy_en   <= 1'b1;
            r_prec     <= w_prec_nxt;
            r_chain    <= w_chain_nxt;
            if (w_first && chain_mode && !chain_legal(prec_mode)) begin
                r_cfg_err <= 1'b1;
            end
            r_vld      <= {r_vld[DSP_LAT-1:0], w_accept};
            r_last     <= {r_last[DSP_LAT-1:0], w_accept && s_last};
            r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_push);
            // Idle cycles feed zeros; their DSP output is never captured.
            r_dsp_a    <= w_accept ? s_a : '0;
            r_dsp_b    <= w_accept ? s_b : '0;
            r_dsp_c    <= w_accept ? s_c : '0;
            if (w_state_nxt != ST_IDLE) begin
                r_dsp_ce    <= w_prec_nxt;
                r_dsp_chain <= w_chain_nxt && chain_legal(w_prec_nxt);
            end else begin
                r_dsp_ce    <= '0;
                r_dsp_chain <= 1'b0;
            end
        end
    end

    dsp_res_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk     (CLK),
        .rst     (SCLR),
        .i_push  (w_push),
        .i_din   ({r_last[DSP_LAT], dsp_p}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign dsp_ce           = r_dsp_ce;
    assign dsp_active_chain = r_dsp_chain;
    assign dsp_a            = r_dsp_a;
    assign dsp_b            = r_dsp_b;
    assign dsp_c            = r_dsp_c;
    assign m_valid          = !w_fifo_empty;
    assign m_data           = m_valid ? w_fifo_dout[DATA_W-1:0] : '0;
    assign m_last           = m_valid && w_fifo_dout[DATA_W];
    assign cfg_err          = r_cfg_err;
    assign busy             = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire
